// File: rtl/core_reg_read_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_reg_read_seq_pkg
// Brief    : Shared types and constants for the operand-read sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package core_reg_read_seq_pkg;

    localparam int c_WORD_W    = 32;
    localparam int c_REG_IDX_W = 5;
    localparam int NUM_GPREGS  = 30;

    typedef logic [c_WORD_W-1:0]    word;
    typedef logic [c_REG_IDX_W-1:0] reg_index;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_HOLD  = 2'd3;

    function automatic logic idx_legal(input reg_index idx, input int nregs);
        return int'(idx) < nregs;
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_reg_read_slot.sv
`default_nettype none
// ============================================================================
// Module   : core_reg_read_slot
// Brief    : One operand slot: capture mux, write snoop, clear, illegal gating.
// Revision : 1.0 - initial release
// ============================================================================
module core_reg_read_slot
    import core_reg_read_seq_pkg::*;
#(
    parameter int NUM_REGS = NUM_GPREGS
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_clear,
    input  logic     i_capture,
    input  logic     i_release,
    input  reg_index i_index,
    input  word      i_rd_value,
    input  logic     i_wr_enable,
    input  reg_index i_wr_index,
    input  word      i_wr_value,
    output word      o_value
);

    logic w_legal;
    logic w_wr_hit;
    word  r_value;
    logic r_live;

    assign w_legal  = idx_legal(i_index, NUM_REGS);
    assign w_wr_hit = i_wr_enable && (i_wr_index == i_index);

    // r_live marks a captured legal value that must track later writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
            r_live  <= 1'b0;
        end else if (i_clear) begin
            r_value <= '0;
            r_live  <= 1'b0;
        end else if (i_capture) begin
            if (w_legal) begin
                r_value <= w_wr_hit ? i_wr_value : i_rd_value;
                r_live  <= 1'b1;
            end else begin
                r_value <= '0;
                r_live  <= 1'b0;
            end
        end else if (i_release) begin
            r_live <= 1'b0;
        end else if (r_live && w_wr_hit) begin
            r_value <= i_wr_value;
        end
    end

    assign o_value = r_value;

endmodule
`default_nettype wire

// File: rtl/core_reg_read_seq.sv
`default_nettype none
// ============================================================================
// Module   : core_reg_read_seq
// Brief    : Issues up to NUM_OPS operand reads on one read port, keeps results coherent.
// Revision : 1.0 - initial release
// ============================================================================
module core_reg_read_seq
    import core_reg_read_seq_pkg::*;
#(
    parameter int NUM_OPS  = 3,
    parameter int NUM_REGS = NUM_GPREGS
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [NUM_OPS-1:0]                   req_mask,
    input  logic [NUM_OPS-1:0][c_REG_IDX_W-1:0]  req_index,
    output logic                                 rsp_valid,
    input  logic                                 rsp_ready,
    output logic [NUM_OPS-1:0][c_WORD_W-1:0]     rsp_value,
    output logic                                 rsp_err,
    output logic [c_REG_IDX_W-1:0]               rf_rd_index,
    input  logic [c_WORD_W-1:0]                  rf_rd_value,
    input  logic                                 wr_enable,
    input  logic [c_REG_IDX_W-1:0]               wr_index,
    input  logic [c_WORD_W-1:0]                  wr_value
);

    localparam int c_PTR_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;

    logic [1:0]                          r_state;
    logic [1:0]                          w_state_nxt;
    logic [c_PTR_W-1:0]                  r_ptr;
    logic [c_PTR_W-1:0]                  r_cap_ptr;
    logic                                r_cap_vld;
    logic [NUM_OPS-1:0]                  r_mask;
    logic [NUM_OPS-1:0][c_REG_IDX_W-1:0] r_index;
    logic                                r_err;

    logic [c_PTR_W-1:0] w_first;
    logic [c_PTR_W-1:0] w_next;
    logic               w_next_found;
    logic [NUM_OPS-1:0] w_req_bad;
    logic               w_clear;
    logic               w_accept;
    reg_index           w_cur_index;

    assign w_clear     = (r_state == c_ST_IDLE) && req_valid;
    assign w_accept    = (r_state == c_ST_HOLD) && rsp_ready;
    assign w_cur_index = r_index[r_ptr];

    // Lowest enabled slot of the incoming request, and next enabled slot after r_ptr
    always_comb begin
        w_first      = '0;
        w_next       = '0;
        w_next_found = 1'b0;
        w_req_bad    = '0;
        for (int i = NUM_OPS - 1; i >= 0; i--) begin
            if (req_mask[i]) begin
                w_first = c_PTR_W'(i);
            end
            if (r_mask[i] && (i > int'(r_ptr))) begin
                w_next       = c_PTR_W'(i);
                w_next_found = 1'b1;
            end
            w_req_bad[i] = req_mask[i] && !idx_legal(req_index[i], NUM_REGS);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (req_valid) w_state_nxt = (req_mask == '0) ? c_ST_HOLD : c_ST_ISSUE;
            c_ST_ISSUE: if (!w_next_found) w_state_nxt = c_ST_DRAIN;
            c_ST_DRAIN: w_state_nxt = c_ST_HOLD;
            c_ST_HOLD:  if (rsp_ready) w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready   = (r_state == c_ST_IDLE);
        rsp_valid   = (r_state == c_ST_HOLD);
        rf_rd_index = '0;
        if ((r_state == c_ST_ISSUE) && idx_legal(w_cur_index, NUM_REGS)) begin
            rf_rd_index = w_cur_index;
        end
    end

    // Read data returns one edge after issue, so the capture strobe lags the pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= '0;
            r_cap_ptr <= '0;
            r_cap_vld <= 1'b0;
            r_mask    <= '0;
            r_index   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_cap_vld <= (r_state == c_ST_ISSUE);
            r_cap_ptr <= r_ptr;
            if (w_clear) begin
                r_ptr   <= w_first;
                r_mask  <= req_mask;
                r_index <= req_index;
                r_err   <= |w_req_bad;
            end else begin
                if ((r_state == c_ST_ISSUE) && w_next_found) begin
                    r_ptr <= w_next;
                end
                if (w_accept) begin
                    r_err <= 1'b0;
                end
            end
        end
    end

    assign rsp_err = r_err;

    generate
        for (genvar g = 0; g < NUM_OPS; g++) begin : g_slot
            core_reg_read_slot #(
                .NUM_REGS (NUM_REGS)
            ) u_slot (
                .clk         (clk),
                .rst_n       (rst_n),
                .i_clear     (w_clear),
                .i_capture   (r_cap_vld && (int'(r_cap_ptr) == g)),
                .i_release   (w_accept),
                .i_index     (r_index[g]),
                .i_rd_value  (rf_rd_value),
                .i_wr_enable (wr_enable),
                .i_wr_index  (wr_index),
                .i_wr_value  (wr_value),
                .o_value     (rsp_value[g])
            );
        end
    endgenerate

endmodule
`default_nettype wire
